qnigma_mdio_phy_init_seq: RTL and testbench
===========================================

// Module: qnigma_mdio_phy_init_seq
// PURPOSE
//  Sequences Clause-22 PHY bring-up over the MDIO register-access engine: soft reset, ID check,
//  AN advertisement, AN restart, link poll, then periodic BMSR link monitoring.
//  Issues one register command at a time on a valid/ready command port and consumes the completion
//  response. Sits between system control (start/status) and the MDIO master feeding the PHY.
// PARAMETERS
//  PHY_ADDR      5'd1         PHY address driven on cmd_phy
//  PHYID1_EXP    16'h001C     expected PHYID1 (reg 2)
//  CHECK_ID      1'b1         1: PHYID1 mismatch -> error; 0: IDs captured only
//  ANAR_VAL      16'h01E1     value written to ANAR (reg 4)
//  POLL_GAP      1000         idle clk cycles between consecutive poll reads (>=1)
//  RST_POLL_MAX  64           max BMCR reads while waiting for reset bit to clear
//  LINK_POLL_MAX 4096         max BMSR reads while waiting for link+AN complete
//  MON_GAP       100000       clk cycles between BMSR reads in MONITOR
// PORTS
//  clk       in   1   clock
//  rst       in   1   asynchronous reset, active-low
//  start     in   1   pulse: begin/restart bring-up sequence
//  cmd_v     out  1   command valid
//  cmd_rdy   in   1   engine accepts command when cmd_v & cmd_rdy
//  cmd_wr    out  1   1 write, 0 read
//  cmd_phy   out  5   PHY address (= PHY_ADDR)
//  cmd_ain   out  5   register address
//  cmd_din   out  16  write data (0 on reads)
//  rsp_v     in   1   1-cycle completion pulse for the accepted command (reads and writes)
//  rsp_dout  in   16  read data, valid with rsp_v
//  busy      out  1   sequence in progress (not IDLE/MONITOR/ERROR)
//  link_up   out  1   BMSR link (bit2) and AN complete (bit5) both seen set
//  err       out  1   sticky until next start; err_code valid
//  err_code  out  2   1 reset timeout, 2 PHYID1 mismatch, 3 link timeout, 0 none
//  phy_id    out  32  {PHYID1,PHYID2} captured in this run
// BEHAVIOUR
//  Reset: all outputs 0 (cmd_phy = PHY_ADDR); state IDLE; counters cleared. Async assert drops cmd_v
//   immediately; any in-flight engine response after reset release is ignored.
//  Handshake: cmd_v/cmd_wr/cmd_ain/cmd_din registered, held stable until cmd_v&cmd_rdy; cmd_v deasserts
//   the next cycle; exactly one outstanding command; next command not issued before rsp_v.
//   rsp_v with no command outstanding is ignored.
//  States (each "CMD" state = issue, then wait rsp_v):
//   IDLE      -> WR_RST on start.
//   WR_RST    write BMCR(0)=16'h8000 -> GAP then RD_BMCR.
//   RD_BMCR   read BMCR; bit15=0 -> RD_ID1; else count++; count==RST_POLL_MAX -> ERROR(1), else GAP.
//   RD_ID1    read reg 2 -> phy_id[31:16]; CHECK_ID & mismatch -> ERROR(2), else RD_ID2.
//   RD_ID2    read reg 3 -> phy_id[15:0] -> WR_ANAR.
//   WR_ANAR   write reg 4 = ANAR_VAL -> WR_AN.
//   WR_AN     write BMCR = 16'h1200 (ANE | restart AN) -> RD_BMSR (poll count cleared).
//   RD_BMSR   read reg 1; bits[5]&[2] -> link_up=1, MONITOR; else count++;
//             count==LINK_POLL_MAX -> ERROR(3), else GAP.
//   GAP       wait POLL_GAP cycles, return to the poll state that entered it.
//   MONITOR   every MON_GAP cycles read BMSR; bit2=0 -> link_up=0, RD_BMSR (count cleared); else stay.
//   ERROR     err=1, err_code held; cmd_v=0; only start leaves.
//  Poll counts are the number of reads returning not-ready; the RST_POLL_MAX-th such read -> timeout.
//  start: ignored while busy; in MONITOR/ERROR restarts at WR_RST (clears err, err_code, link_up,
//   phy_id, counters). Not sampled in the same cycle a command is accepted.
//  BMSR bit2 is latch-low in the PHY: a single 0 read in MONITOR drops link_up.
//  Counters sized by $clog2(max+1); no wrap (saturate at limit, which forces transition).
// TESTING
//  PHY model clears BMCR[15] after 3 reads, ID 001C/C915, link+AN after 5 BMSR reads; start ->
//   writes 8000, 01E1, 1200 in order; link_up=1, phy_id=32'h001CC915, err=0.
//  BMCR[15] stuck 1, RST_POLL_MAX=4 -> exactly 4 BMCR reads, err=1, err_code=1, no ANAR write.
//  PHYID1 returns 16'h0022, CHECK_ID=1 -> err_code=2 after RD_ID1, no reg-3 read.
//  cmd_rdy low 20 cycles per command -> cmd_v/ain/din stable throughout, one command outstanding.
//  In MONITOR, model returns BMSR=16'h7809 once -> link_up=0, re-poll; link restored -> link_up=1.
//  rst low while WR_ANAR awaiting rsp_v -> cmd_v=0 same cycle; stray rsp_v ignored; start reruns.

Source files
------------

// File: rtl/qnigma_mdio_phy_init_seq.sv
// Clause-22 PHY bring-up sequencer: soft reset, ID check, AN setup, link poll, then BMSR monitoring.
// Issues one register command at a time over a valid/ready port and consumes the completion pulse.
module qnigma_mdio_phy_init_seq #(
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter logic [15:0] PHYID1_EXP    = 16'h001C,
    parameter bit          CHECK_ID      = 1'b1,
    parameter logic [15:0] ANAR_VAL      = 16'h01E1,
    parameter int          POLL_GAP      = 1000,
    parameter int          RST_POLL_MAX  = 64,
    parameter int          LINK_POLL_MAX = 4096,
    parameter int          MON_GAP       = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_cmd_v,
    input  logic        i_cmd_rdy,
    output logic        o_cmd_wr,
    output logic [4:0]  o_cmd_phy,
    output logic [4:0]  o_cmd_ain,
    output logic [15:0] o_cmd_din,
    input  logic        i_rsp_v,
    input  logic [15:0] i_rsp_dout,
    output logic        o_busy,
    output logic        o_link_up,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [31:0] o_phy_id
);
    localparam int PMAX = (RST_POLL_MAX > LINK_POLL_MAX) ? RST_POLL_MAX : LINK_POLL_MAX;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int GMAX = (POLL_GAP > MON_GAP) ? POLL_GAP : MON_GAP;
    localparam int TW   = $clog2(GMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_RST, S_RD_BMCR, S_RD_ID1, S_RD_ID2, S_WR_ANAR,
        S_WR_AN, S_RD_BMSR, S_GAP, S_MONITOR, S_ERROR
    } state_t;

    state_t        r_state, w_state, r_ret, w_ret;
    logic          r_sent, w_sent, r_out, w_out;
    logic          r_cmd_v, w_cmd_v, r_cmd_wr, w_cmd_wr;
    logic [4:0]    r_cmd_ain, w_cmd_ain;
    logic [15:0]   r_cmd_din, w_cmd_din;
    logic [PW-1:0] r_poll, w_poll, w_poll_inc;
    logic [TW-1:0] r_tmr, w_tmr;
    logic          r_link, w_link, r_err, w_err;
    logic [1:0]    r_code, w_code;
    logic [31:0]   r_id, w_id;
    logic          w_done, w_is_cmd, w_issue, w_restart;
    logic          w_req_wr;
    logic [4:0]    w_req_ain;
    logic [15:0]   w_req_din;

    // Register command belonging to each command-issuing state
    always_comb begin
        w_req_wr  = 1'b0;
        w_req_ain = 5'd0;
        w_req_din = 16'h0000;
        w_is_cmd  = 1'b1;
        case (r_state)
            S_WR_RST:  begin w_req_wr = 1'b1; w_req_din = 16'h8000; end
            S_RD_BMCR: w_req_ain = 5'd0;
            S_RD_ID1:  w_req_ain = 5'd2;
            S_RD_ID2:  w_req_ain = 5'd3;
            S_WR_ANAR: begin w_req_wr = 1'b1; w_req_ain = 5'd4; w_req_din = ANAR_VAL; end
            S_WR_AN:   begin w_req_wr = 1'b1; w_req_din = 16'h1200; end
            S_RD_BMSR: w_req_ain = 5'd1;
            S_MONITOR: begin w_req_ain = 5'd1; w_is_cmd = 1'b0; end
            default:   w_is_cmd = 1'b0;
        endcase
    end

    always_comb begin
        w_state    = r_state;
        w_ret      = r_ret;
        w_sent     = r_sent;
        w_out      = r_out;
        w_cmd_v    = r_cmd_v;
        w_cmd_wr   = r_cmd_wr;
        w_cmd_ain  = r_cmd_ain;
        w_cmd_din  = r_cmd_din;
        w_poll     = r_poll;
        w_tmr      = r_tmr;
        w_link     = r_link;
        w_err      = r_err;
        w_code     = r_code;
        w_id       = r_id;
        w_restart  = 1'b0;
        w_issue    = w_is_cmd & ~r_sent;
        w_done     = r_out & i_rsp_v;
        w_poll_inc = r_poll + PW'(1);

        if (r_cmd_v && i_cmd_rdy) begin
            w_cmd_v = 1'b0;
            w_out   = 1'b1;
        end
        if (w_done) begin
            w_out  = 1'b0;
            w_sent = 1'b0;
        end

        case (r_state)
            S_IDLE, S_ERROR: w_restart = i_start;
            S_WR_RST: if (w_done) begin
                w_state = S_GAP;
                w_ret   = S_RD_BMCR;
                w_tmr   = TW'(POLL_GAP - 1);
            end
            S_RD_BMCR: if (w_done) begin
                if (!i_rsp_dout[15]) begin
                    w_state = S_RD_ID1;
                end else if (w_poll_inc == PW'(RST_POLL_MAX)) begin
                    w_poll  = w_poll_inc;
                    w_state = S_ERROR;
                    w_err   = 1'b1;
                    w_code  = 2'd1;
                end else begin
                    w_poll  = w_poll_inc;
                    w_state = S_GAP;
                    w_ret   = S_RD_BMCR;
                    w_tmr   = TW'(POLL_GAP - 1);
                end
            end
            S_RD_ID1: if (w_done) begin
                w_id[31:16] = i_rsp_dout;
                if (CHECK_ID && (i_rsp_dout != PHYID1_EXP)) begin
                    w_state = S_ERROR;
                    w_err   = 1'b1;
                    w_code  = 2'd2;
                end else begin
                    w_state = S_RD_ID2;
                end
            end
            S_RD_ID2: if (w_done) begin
                w_id[15:0] = i_rsp_dout;
                w_state    = S_WR_ANAR;
            end
            S_WR_ANAR: if (w_done) w_state = S_WR_AN;
            S_WR_AN: if (w_done) begin
                w_state = S_RD_BMSR;
                w_poll  = '0;
            end
            S_RD_BMSR: if (w_done) begin
                if (i_rsp_dout[5] && i_rsp_dout[2]) begin
                    w_link  = 1'b1;
                    w_state = S_MONITOR;
                    w_tmr   = TW'(MON_GAP - 1);
                end else if (w_poll_inc == PW'(LINK_POLL_MAX)) begin
                    w_poll  = w_poll_inc;
                    w_state = S_ERROR;
                    w_err   = 1'b1;
                    w_code  = 2'd3;
                end else begin
                    w_poll  = w_poll_inc;
                    w_state = S_GAP;
                    w_ret   = S_RD_BMSR;
                    w_tmr   = TW'(POLL_GAP - 1);
                end
            end
            S_GAP: begin
                if (r_tmr == '0) w_state = r_ret;
                else             w_tmr   = r_tmr - TW'(1);
            end
            S_MONITOR: begin
                // A restart is only taken with no command in flight, so no stale response can leak in
                if (!r_sent) begin
                    if (i_start)           w_restart = 1'b1;
                    else if (r_tmr == '0)  w_issue   = 1'b1;
                    else                   w_tmr     = r_tmr - TW'(1);
                end else if (w_done) begin
                    if (!i_rsp_dout[2]) begin
                        w_link  = 1'b0;
                        w_state = S_RD_BMSR;
                        w_poll  = '0;
                    end else begin
                        w_tmr = TW'(MON_GAP - 1);
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (w_restart) begin
            w_state = S_WR_RST;
            w_issue = 1'b0;
            w_sent  = 1'b0;
            w_out   = 1'b0;
            w_cmd_v = 1'b0;
            w_err   = 1'b0;
            w_code  = 2'd0;
            w_link  = 1'b0;
            w_id    = 32'h0;
            w_poll  = '0;
        end else if (w_issue) begin
            w_cmd_v   = 1'b1;
            w_cmd_wr  = w_req_wr;
            w_cmd_ain = w_req_ain;
            w_cmd_din = w_req_din;
            w_sent    = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_ret     <= S_RD_BMCR;
            r_sent    <= 1'b0;
            r_out     <= 1'b0;
            r_cmd_v   <= 1'b0;
            r_cmd_wr  <= 1'b0;
            r_cmd_ain <= 5'd0;
            r_cmd_din <= 16'h0000;
            r_poll    <= '0;
            r_tmr     <= '0;
            r_link    <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= 2'd0;
            r_id      <= 32'h0;
        end else begin
            r_state   <= w_state;
            r_ret     <= w_ret;
            r_sent    <= w_sent;
            r_out     <= w_out;
            r_cmd_v   <= w_cmd_v;
            r_cmd_wr  <= w_cmd_wr;
            r_cmd_ain <= w_cmd_ain;
            r_cmd_din <= w_cmd_din;
            r_poll    <= w_poll;
            r_tmr     <= w_tmr;
            r_link    <= w_link;
            r_err     <= w_err;
            r_code    <= w_code;
            r_id      <= w_id;
        end
    end

    assign o_cmd_v    = r_cmd_v;
    assign o_cmd_wr   = r_cmd_wr;
    assign o_cmd_phy  = PHY_ADDR;
    assign o_cmd_ain  = r_cmd_ain;
    assign o_cmd_din  = r_cmd_din;
    assign o_busy     = !((r_state == S_IDLE) || (r_state == S_MONITOR) || (r_state == S_ERROR));
    assign o_link_up  = r_link;
    assign o_err      = r_err;
    assign o_err_code = r_code;
    assign o_phy_id   = r_id;

endmodule

// File: tb/tb_qnigma_mdio_phy_init_seq.sv
// Bench for qnigma_mdio_phy_init_seq: a behavioural PHY/engine model answers commands, and each
// scenario compares the observed command log and status against a list derived from the PHY behaviour.
module tb_qnigma_mdio_phy_init_seq;
    localparam int POLL_GAP = 3;
    localparam int RST_MAX  = 4;
    localparam int LINK_MAX = 8;
    localparam int MON_GAP  = 40;
    localparam logic [15:0] ID1_EXP = 16'h001C;

    logic        clk, rst_n, start;
    logic        cmd_v, cmd_rdy, cmd_wr, rsp_v;
    logic [4:0]  cmd_phy, cmd_ain;
    logic [15:0] cmd_din, rsp_dout;
    logic        busy, link_up, err;
    logic [1:0]  err_code;
    logic [31:0] phy_id;

    int total = 0;
    int bad   = 0;

    typedef logic [21:0] cmd_t;  // {wr, ain, din}
    cmd_t log_q[$];
    cmd_t exp_q[$];

    int          m_rst_busy, m_link_after, m_bmcr_reads, m_bmsr_reads;
    logic [15:0] m_id1, m_id2;
    bit          m_drop_once = 0;
    int          fixed_rdy   = -1;
    bit          stall_anar  = 0;
    bit          stray_req   = 0;
    int          eng_phase   = 0;
    int          stab_err    = 0;
    int          proto_err   = 0;

    qnigma_mdio_phy_init_seq #(
        .POLL_GAP(POLL_GAP), .RST_POLL_MAX(RST_MAX), .LINK_POLL_MAX(LINK_MAX), .MON_GAP(MON_GAP)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_cmd_v(cmd_v), .i_cmd_rdy(cmd_rdy), .o_cmd_wr(cmd_wr), .o_cmd_phy(cmd_phy),
        .o_cmd_ain(cmd_ain), .o_cmd_din(cmd_din), .i_rsp_v(rsp_v), .i_rsp_dout(rsp_dout),
        .o_busy(busy), .o_link_up(link_up), .o_err(err), .o_err_code(err_code), .o_phy_id(phy_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // PHY register behaviour: BMCR reset bit clears after m_rst_busy reads, link after m_link_after BMSR reads
    task automatic phy_read(input logic [4:0] ain, output logic [15:0] d);
        d = 16'h0000;
        case (ain)
            5'd0: begin
                m_bmcr_reads++;
                d = (m_bmcr_reads <= m_rst_busy) ? 16'h9140 : 16'h1140;
            end
            5'd1: begin
                m_bmsr_reads++;
                if (m_drop_once) begin
                    d = 16'h7809;
                    m_drop_once = 0;
                end else begin
                    d = (m_bmsr_reads > m_link_after) ? 16'h782D : 16'h7809;
                end
            end
            5'd2: d = m_id1;
            5'd3: d = m_id2;
            default: d = 16'h0000;
        endcase
    endtask

    // Register-access engine: random accept delay and response latency, watches handshake rules
    initial begin : engine
        logic        s_wr;
        logic [4:0]  s_ain, s_phy;
        logic [15:0] s_din, s_data;
        int          wait_cnt, lat;
        cmd_rdy = 1'b0; rsp_v = 1'b0; rsp_dout = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cmd_rdy = 1'b0; rsp_v = 1'b0; eng_phase = 0;
            end else begin
                case (eng_phase)
                    0: if (stray_req) begin
                        rsp_v = 1'b1; rsp_dout = 16'hFFFF; stray_req = 0; eng_phase = 5;
                    end else if (cmd_v) begin
                        s_wr = cmd_wr; s_ain = cmd_ain; s_din = cmd_din; s_phy = cmd_phy;
                        if (stall_anar && s_wr && s_ain == 5'd4) wait_cnt = 100000;
                        else if (fixed_rdy >= 0)                 wait_cnt = fixed_rdy;
                        else                                     wait_cnt = int'($urandom_range(0, 3));
                        if (s_phy !== 5'd1 || (!s_wr && s_din !== 16'h0)) proto_err++;
                        if (wait_cnt == 0) begin cmd_rdy = 1'b1; eng_phase = 2; end
                        else eng_phase = 1;
                    end
                    1: begin
                        if (cmd_v !== 1'b1 || cmd_wr !== s_wr || cmd_ain !== s_ain || cmd_din !== s_din)
                            stab_err++;
                        wait_cnt--;
                        if (wait_cnt == 0) begin cmd_rdy = 1'b1; eng_phase = 2; end
                    end
                    2: begin
                        cmd_rdy = 1'b0;
                        if (cmd_v !== 1'b0) proto_err++;
                        log_q.push_back({s_wr, s_ain, s_din});
                        if (s_wr) s_data = 16'h0000;
                        else      phy_read(s_ain, s_data);
                        lat = int'($urandom_range(0, 3));
                        eng_phase = 3;
                    end
                    3: begin
                        if (cmd_v !== 1'b0) proto_err++;
                        if (lat == 0) begin rsp_v = 1'b1; rsp_dout = s_data; eng_phase = 4; end
                        else lat--;
                    end
                    default: begin rsp_v = 1'b0; rsp_dout = 16'h0000; eng_phase = 0; end
                endcase
            end
        end
    end

    // Expected command list from the bring-up rules and the configured PHY behaviour
    task automatic build_expected(input int r, input logic [15:0] id1, input int l, output int code);
        int n;
        exp_q.delete();
        code = 0;
        exp_q.push_back({1'b1, 5'd0, 16'h8000});
        n = (r >= RST_MAX) ? RST_MAX : r + 1;
        repeat (n) exp_q.push_back({1'b0, 5'd0, 16'h0000});
        if (r >= RST_MAX) begin code = 1; return; end
        exp_q.push_back({1'b0, 5'd2, 16'h0000});
        if (id1 != ID1_EXP) begin code = 2; return; end
        exp_q.push_back({1'b0, 5'd3, 16'h0000});
        exp_q.push_back({1'b1, 5'd4, 16'h01E1});
        exp_q.push_back({1'b1, 5'd0, 16'h1200});
        n = (l >= LINK_MAX) ? LINK_MAX : l + 1;
        repeat (n) exp_q.push_back({1'b0, 5'd1, 16'h0000});
        if (l >= LINK_MAX) code = 3;
    endtask

    function automatic int first_diff();
        int n;
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (log_q[i] !== exp_q[i]) return i;
        if (log_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic quiesce(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (eng_phase == 0 && !cmd_v && !stray_req) begin ok = 1; return; end
        end
    endtask

    task automatic begin_run(input int r, input logic [15:0] id1, input logic [15:0] id2, input int l,
                             output bit ok);
        quiesce(ok);
        m_rst_busy = r; m_link_after = l; m_id1 = id1; m_id2 = id2;
        m_bmcr_reads = 0; m_bmsr_reads = 0; m_drop_once = 0;
        log_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_settle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin ok = 1; return; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (cmd_v !== 1'b0)     begin bad++; $display("FAIL reset cmd_v got=%b exp=0", cmd_v); end
        total++; if (cmd_phy !== 5'd1)   begin bad++; $display("FAIL reset cmd_phy got=%0d exp=1", cmd_phy); end
        total++; if ({cmd_wr, cmd_ain, cmd_din} !== 22'h0)
                                         begin bad++; $display("FAIL reset cmd fields got=%h exp=0", {cmd_wr, cmd_ain, cmd_din}); end
        total++; if ({busy, link_up, err, err_code} !== 5'b0)
                                         begin bad++; $display("FAIL reset status got=%b exp=00000", {busy, link_up, err, err_code}); end
        total++; if (phy_id !== 32'h0)   begin bad++; $display("FAIL reset phy_id got=%h exp=0", phy_id); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || cmd_v !== 1'b0)
                                         begin bad++; $display("FAIL idle_no_start busy=%b cmd_v=%b exp=0,0", busy, cmd_v); end
    endtask

    task automatic test_bringup();
        bit ok; int code, d;
        begin_run(3, 16'h001C, 16'hC915, 5, ok);
        wait_settle(3000, ok);
        build_expected(3, 16'h001C, 5, code);
        d = first_diff();
        total++; if (!ok)        begin bad++; $display("FAIL bringup settle timeout got=busy exp=done"); end
        total++; if (d != -1)    begin bad++; $display("FAIL bringup cmd_seq diff_at=%0d got_n=%0d exp_n=%0d", d, log_q.size(), exp_q.size()); end
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL bringup link_up got=%b exp=1", link_up); end
        total++; if (phy_id !== 32'h001CC915) begin bad++; $display("FAIL bringup phy_id got=%h exp=001cc915", phy_id); end
        total++; if (err !== 1'b0 || err_code !== 2'd0) begin bad++; $display("FAIL bringup err got=%b/%0d exp=0/0", err, err_code); end
    endtask

    task automatic test_monitor();
        bit ok; int n0, n1, dn, nonbmsr;
        n0 = log_q.size();
        repeat (150) @(posedge clk);
        #1;
        dn = log_q.size() - n0;
        nonbmsr = 0;
        for (int i = n0; i < log_q.size(); i++) if (log_q[i] !== {1'b0, 5'd1, 16'h0}) nonbmsr++;
        total++; if (dn < 2 || dn > 4) begin bad++; $display("FAIL monitor_period reads got=%0d exp=2..4", dn); end
        total++; if (nonbmsr != 0)     begin bad++; $display("FAIL monitor_reads non_bmsr got=%0d exp=0", nonbmsr); end
        m_drop_once = 1;
        n1 = log_q.size();
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!link_up) begin ok = 1; break; end
        end
        total++; if (!ok)          begin bad++; $display("FAIL monitor_drop link_up got=1 exp=0"); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL monitor_drop busy got=%b exp=1", busy); end
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (link_up) begin ok = 1; break; end
        end
        total++; if (!ok || busy !== 1'b0) begin bad++; $display("FAIL monitor_restore link_up=%b busy=%b exp=1,0", link_up, busy); end
        total++; if (log_q.size() - n1 != 2) begin bad++; $display("FAIL monitor_repoll reads got=%0d exp=2", log_q.size() - n1); end
    endtask

    task automatic test_rst_timeout();
        bit ok; int code, d;
        begin_run(1000, 16'h001C, 16'hC915, 0, ok);
        wait_settle(3000, ok);
        build_expected(1000, 16'h001C, 0, code);
        d = first_diff();
        total++; if (!ok || d != -1) begin bad++; $display("FAIL rst_timeout cmd_seq ok=%0d diff_at=%0d got_n=%0d exp_n=%0d", ok, d, log_q.size(), exp_q.size()); end
        total++; if (m_bmcr_reads != RST_MAX) begin bad++; $display("FAIL rst_timeout bmcr_reads got=%0d exp=%0d", m_bmcr_reads, RST_MAX); end
        total++; if (err !== 1'b1 || err_code !== 2'd1) begin bad++; $display("FAIL rst_timeout err got=%b/%0d exp=1/1", err, err_code); end
        total++; if (link_up !== 1'b0 || phy_id !== 32'h0) begin bad++; $display("FAIL rst_timeout cleared link=%b id=%h exp=0/0", link_up, phy_id); end
    endtask

    task automatic test_id_mismatch();
        bit ok; int code, d;
        begin_run(0, 16'h0022, 16'hC915, 0, ok);
        wait_settle(3000, ok);
        build_expected(0, 16'h0022, 0, code);
        d = first_diff();
        total++; if (!ok || d != -1) begin bad++; $display("FAIL id_mismatch cmd_seq ok=%0d diff_at=%0d got_n=%0d exp_n=%0d", ok, d, log_q.size(), exp_q.size()); end
        total++; if (err !== 1'b1 || err_code !== 2'd2) begin bad++; $display("FAIL id_mismatch err got=%b/%0d exp=1/2", err, err_code); end
        total++; if (phy_id !== 32'h00220000) begin bad++; $display("FAIL id_mismatch phy_id got=%h exp=00220000", phy_id); end
    endtask

    task automatic test_link_timeout();
        bit ok; int code, d;
        begin_run(1, 16'h001C, 16'h1234, 1000, ok);
        wait_settle(3000, ok);
        build_expected(1, 16'h001C, 1000, code);
        d = first_diff();
        total++; if (!ok || d != -1) begin bad++; $display("FAIL link_timeout cmd_seq ok=%0d diff_at=%0d got_n=%0d exp_n=%0d", ok, d, log_q.size(), exp_q.size()); end
        total++; if (m_bmsr_reads != LINK_MAX) begin bad++; $display("FAIL link_timeout bmsr_reads got=%0d exp=%0d", m_bmsr_reads, LINK_MAX); end
        total++; if (err !== 1'b1 || err_code !== 2'd3 || link_up !== 1'b0) begin bad++; $display("FAIL link_timeout status got=%b/%0d/%b exp=1/3/0", err, err_code, link_up); end
    endtask

    task automatic test_stall();
        bit ok; int code, d;
        logic [15:0] id2;
        id2 = 16'($urandom);
        fixed_rdy = 20;
        begin_run(2, 16'h001C, id2, 3, ok);
        wait_settle(5000, ok);
        fixed_rdy = -1;
        build_expected(2, 16'h001C, 3, code);
        d = first_diff();
        total++; if (!ok || d != -1) begin bad++; $display("FAIL stall cmd_seq ok=%0d diff_at=%0d got_n=%0d exp_n=%0d", ok, d, log_q.size(), exp_q.size()); end
        total++; if (stab_err != 0)  begin bad++; $display("FAIL stall stability errors got=%0d exp=0", stab_err); end
        total++; if (proto_err != 0) begin bad++; $display("FAIL stall handshake errors got=%0d exp=0", proto_err); end
        total++; if (link_up !== 1'b1 || phy_id !== {16'h001C, id2}) begin bad++; $display("FAIL stall result link=%b id=%h exp=1/%h", link_up, phy_id, {16'h001C, id2}); end
    endtask

    task automatic test_back_to_back();
        bit ok; int code, d, r, l;
        logic [15:0] id1, id2, exp_id1;
        logic [31:0] exp_id;
        for (int it = 0; it < 6; it++) begin
            r   = int'($urandom_range(0, 5));
            l   = int'($urandom_range(0, 9));
            id1 = ($urandom_range(0, 3) == 0) ? 16'h0022 : 16'h001C;
            id2 = 16'($urandom);
            begin_run(r, id1, id2, l, ok);
            repeat (4) @(posedge clk);
            #1;
            start = 1'b1;  // still busy here, so this pulse must change nothing
            @(posedge clk); #1;
            start = 1'b0;
            wait_settle(3000, ok);
            build_expected(r, id1, l, code);
            d = first_diff();
            exp_id1 = (code == 1) ? 16'h0 : id1;
            exp_id  = (code == 0 || code == 3) ? {id1, id2} : {exp_id1, 16'h0};
            total++; if (!ok || d != -1) begin bad++; $display("FAIL b2b[%0d] cmd_seq r=%0d l=%0d diff_at=%0d got_n=%0d exp_n=%0d", it, r, l, d, log_q.size(), exp_q.size()); end
            total++; if (err_code !== 2'(code) || err !== (code != 0)) begin bad++; $display("FAIL b2b[%0d] err got=%b/%0d exp=%0d/%0d", it, err, err_code, code != 0, code); end
            total++; if (link_up !== (code == 0)) begin bad++; $display("FAIL b2b[%0d] link_up got=%b exp=%0d", it, link_up, code == 0); end
            total++; if (phy_id !== exp_id) begin bad++; $display("FAIL b2b[%0d] phy_id got=%h exp=%h", it, phy_id, exp_id); end
        end
    endtask

    task automatic test_async_reset();
        bit ok; int code, d;
        stall_anar = 1;
        begin_run(0, 16'h001C, 16'hC915, 0, ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (cmd_v && cmd_wr && cmd_ain == 5'd4) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL async_rst anar_wait got=absent exp=ANAR write pending"); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (cmd_v !== 1'b0) begin bad++; $display("FAIL async_rst cmd_v got=%b exp=0", cmd_v); end
        total++; if (busy !== 1'b0 || phy_id !== 32'h0) begin bad++; $display("FAIL async_rst state busy=%b id=%h exp=0/0", busy, phy_id); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall_anar = 0;
        stray_req = 1;
        repeat (6) @(posedge clk);
        #1;
        total++; if (cmd_v !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL stray_rsp cmd_v=%b busy=%b err=%b exp=0,0,0", cmd_v, busy, err); end
        begin_run(1, 16'h001C, 16'hC915, 2, ok);
        wait_settle(3000, ok);
        build_expected(1, 16'h001C, 2, code);
        d = first_diff();
        total++; if (!ok || d != -1) begin bad++; $display("FAIL rerun cmd_seq ok=%0d diff_at=%0d got_n=%0d exp_n=%0d", ok, d, log_q.size(), exp_q.size()); end
        total++; if (link_up !== 1'b1 || phy_id !== 32'h001CC915) begin bad++; $display("FAIL rerun result link=%b id=%h exp=1/001cc915", link_up, phy_id); end
        total++; if (stab_err != 0 || proto_err != 0) begin bad++; $display("FAIL handshake totals stab=%0d proto=%0d exp=0/0", stab_err, proto_err); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_bringup();
        test_monitor();
        test_rst_timeout();
        test_id_mismatch();
        test_link_timeout();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
